// File: rtl/tohost_console.sv
// Tohost console: decodes core tohost writes into print/poweroff commands, buffers
// printed characters and serialises them as 8N1 UART frames. Optional macro: TOHOST_STALL_EN.
module tohost_console #(
    parameter int QUEUE_SIZE  = 64,
    parameter int SERIAL_WCNT = 100
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_we,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_txd,
    output logic        o_poweroff,
    output logic [15:0] o_exit_code,
    output logic        o_busy,
    output logic [7:0]  o_drop_cnt
);
    localparam int AW = $clog2(QUEUE_SIZE);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(SERIAL_WCNT);
    localparam logic [CW-1:0] FULL   = CW'(QUEUE_SIZE);
    localparam logic [WW-1:0] W_LAST = WW'(SERIAL_WCNT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STOP} tx_state_t;

    logic unused_bits;
    assign unused_bits = ^{i_addr[31], i_addr[29:16], i_addr[14:0], i_we[3:1], i_wdata[31:18]};

    // ---- stage p0: registered tohost decode
    logic        vld_p0;
    logic [1:0]  cmd_p0;
    logic [15:0] arg_p0;

    always_ff @(posedge CLK) begin
        if (!RST_X) vld_p0 <= 1'b0;
        else        vld_p0 <= i_addr[30] & i_addr[15] & i_we[0];
        cmd_p0 <= i_wdata[17:16];
        arg_p0 <= i_wdata[15:0];
    end

    logic print_p0, power_p0;
    assign print_p0 = vld_p0 & (cmd_p0 == 2'd1);
    assign power_p0 = vld_p0 & (cmd_p0 == 2'd2);

    // ---- stage p1: command takes effect (queue, poweroff, drop count)
    logic [7:0]    mem [QUEUE_SIZE];
    logic [AW-1:0] head;
    logic [CW-1:0] count;
    logic [AW-1:0] tail;
    logic          deq, enq;
    tx_state_t     state, state_nxt;

    assign deq  = (state == IDLE) && (count != '0);
    assign enq  = print_p0 && ((count != FULL) || deq);
    assign tail = head + count[AW-1:0];

    always_ff @(posedge CLK) begin
        if (enq) mem[tail] <= arg_p0[7:0];
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            head  <= '0;
            count <= '0;
        end else begin
            if (deq) head <= head + AW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            o_poweroff  <= 1'b0;
            o_exit_code <= '0;
        end else if (power_p0 && !o_poweroff) begin
            o_poweroff  <= 1'b1;
            o_exit_code <= arg_p0;
        end
    end

`ifdef TOHOST_STALL_EN
    // Threshold leaves room for the hits already in flight when stall becomes visible.
    always_ff @(posedge CLK) begin
        if (!RST_X) o_stall <= 1'b0;
        else        o_stall <= (count >= FULL - CW'(2));
    end
    assign o_drop_cnt = 8'd0;
`else
    assign o_stall = 1'b0;
    always_ff @(posedge CLK) begin
        if (!RST_X)
            o_drop_cnt <= 8'd0;
        else if (print_p0 && !enq && (o_drop_cnt != 8'hFF))
            o_drop_cnt <= o_drop_cnt + 8'd1;
    end
`endif

    // ---- transmitter: bit_idx 0 is the start bit, 1..8 the data bits
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic [3:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    tx_data, tx_data_nxt;
    logic          txd_nxt;
    logic          wlast;

    assign wlast = (wcnt == W_LAST);

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt + WW'(1);
        bit_idx_nxt = bit_idx;
        tx_data_nxt = tx_data;
        txd_nxt     = o_txd;
        case (state)
            IDLE: begin
                wcnt_nxt = '0;
                txd_nxt  = 1'b1;
                if (deq) begin
                    state_nxt   = SHIFT;
                    bit_idx_nxt = '0;
                    tx_data_nxt = mem[head];
                    txd_nxt     = 1'b0;
                end
            end
            SHIFT: begin
                if (wlast) begin
                    wcnt_nxt = '0;
                    if (bit_idx == 4'd8) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 4'd1;
                        txd_nxt     = tx_data[bit_idx[2:0]];
                    end
                end
            end
            STOP: begin
                if (wlast) begin
                    wcnt_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state   <= IDLE;
            wcnt    <= '0;
            bit_idx <= '0;
            o_txd   <= 1'b1;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            bit_idx <= bit_idx_nxt;
            o_txd   <= txd_nxt;
        end
        tx_data <= tx_data_nxt;
    end

    assign o_busy = (count != '0) | (state != IDLE) | print_p0;

endmodule

// File: tb/tb_tohost_console.sv
// Bench for tohost_console: randomized tohost traffic against a list-based model,
// with a UART receiver that decodes o_txd and checks bit timing.
module tb_tohost_console;
    localparam int QS    = 64;
    localparam int WC    = 8;
    localparam int FRAME = 10 * WC;
    localparam logic [31:0] TOHOST = 32'h4000_8000;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic [31:0] i_addr = '0;
    logic [3:0]  i_we = '0;
    logic [31:0] i_wdata = '0;
    logic        o_stall, o_txd, o_poweroff, o_busy;
    logic [15:0] o_exit_code;
    logic [7:0]  o_drop_cnt;

    int chk_cnt = 0;
    int pass_cnt = 0;

    tohost_console #(.QUEUE_SIZE(QS), .SERIAL_WCNT(WC)) dut (
        .CLK(CLK), .RST_X(RST_X), .i_addr(i_addr), .i_we(i_we), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_txd(o_txd), .o_poweroff(o_poweroff),
        .o_exit_code(o_exit_code), .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
    );

    always #5 CLK = ~CLK;

    // UART receiver: every bit must hold its level for exactly WC samples
    logic [7:0] rx_q[$];
    int         rx_err = 0;
    bit         rx_act = 0;
    int         rx_pos = 0;
    logic       rx_lvl = 1'b1;
    logic [7:0] rx_sh = '0;

    always @(negedge CLK) begin
        if (!RST_X) begin
            rx_act = 0;
        end else if (!rx_act) begin
            if (o_txd === 1'b0) begin
                rx_act = 1; rx_pos = 0; rx_lvl = 1'b0;
            end else if (o_txd !== 1'b1) begin
                rx_err++;
            end
        end else begin
            rx_pos++;
            if (rx_pos % WC == 0) begin
                rx_lvl = o_txd;
                if (rx_pos / WC <= 8) rx_sh = {o_txd, rx_sh[7:1]};
                else if (o_txd !== 1'b1) rx_err++;
            end else if (o_txd !== rx_lvl) begin
                rx_err++;
            end
            if (rx_pos == FRAME - 1) begin
                rx_q.push_back(rx_sh);
                rx_act = 0;
            end
        end
    end

    function automatic logic [7:0] burst_ch(input int i);
        return 8'(i * 37 + 11);
    endfunction

    task automatic cyc(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        i_addr = a; i_we = we; i_wdata = d;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, '0, '0);
    endtask

    task automatic do_reset();
        RST_X = 1'b0;
        idle(2);
        RST_X = 1'b1;
        idle(1);
        rx_q.delete();
        rx_err = 0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n;
        n = 0;
        ok = 0;
        while (n < budget) begin
            if (!o_busy && !rx_act) begin ok = 1; break; end
            idle(1);
            n++;
        end
    endtask

    task automatic test_reset();
        RST_X = 1'b0;
        cyc(TOHOST, 4'b0001, 32'h0001_0055);
        idle(2);
        chk_cnt++; if (o_txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", o_txd); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
        chk_cnt++; if (o_poweroff !== 1'b0) $display("FAIL reset_poweroff: got %b want 0", o_poweroff); else pass_cnt++;
        chk_cnt++; if (o_exit_code !== 16'h0) $display("FAIL reset_exit: got %h want 0000", o_exit_code); else pass_cnt++;
        chk_cnt++; if (o_drop_cnt !== 8'h0) $display("FAIL reset_drop: got %0d want 0", o_drop_cnt); else pass_cnt++;
        chk_cnt++; if (o_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", o_stall); else pass_cnt++;
        RST_X = 1'b1;
        idle(2);
        rx_q.delete();
        rx_err = 0;
    endtask

    task automatic test_single_char();
        int lat;
        bit ok;
        cyc(TOHOST, 4'b0001, 32'h0001_0041);
        lat = 1;
        while (o_txd !== 1'b0 && lat < 10) begin idle(1); lat++; end
        chk_cnt++; if (lat < 3 || lat > 4) $display("FAIL start_latency: got %0d want 3..4", lat); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b1) $display("FAIL busy_in_frame: got %b want 1", o_busy); else pass_cnt++;
        wait_drain(3 * FRAME, ok);
        chk_cnt++; if (!ok) $display("FAIL single_drain: busy still %b want 0", o_busy); else pass_cnt++;
        chk_cnt++; if (rx_q.size() != 1) $display("FAIL single_count: got %0d want 1", rx_q.size()); else pass_cnt++;
        chk_cnt++; if (rx_q.size() < 1 || rx_q[0] !== 8'h41) $display("FAIL single_char: got %h want 41", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); else pass_cnt++;
        chk_cnt++; if (rx_err != 0) $display("FAIL single_timing: got %0d errors want 0", rx_err); else pass_cnt++;
        chk_cnt++; if (o_txd !== 1'b1) $display("FAIL single_idle_txd: got %b want 1", o_txd); else pass_cnt++;
    endtask

    task automatic test_poweroff();
        cyc(TOHOST, 4'b0001, 32'h0002_0007);
        chk_cnt++; if (o_poweroff !== 1'b0) $display("FAIL poweroff_early: got %b want 0", o_poweroff); else pass_cnt++;
        idle(1);
        chk_cnt++; if (o_poweroff !== 1'b1) $display("FAIL poweroff_set: got %b want 1", o_poweroff); else pass_cnt++;
        chk_cnt++; if (o_exit_code !== 16'h0007) $display("FAIL exit_code: got %h want 0007", o_exit_code); else pass_cnt++;
        cyc(TOHOST, 4'b0001, 32'h0002_0003);
        idle(3);
        chk_cnt++; if (o_exit_code !== 16'h0007) $display("FAIL exit_sticky: got %h want 0007", o_exit_code); else pass_cnt++;
        chk_cnt++; if (o_poweroff !== 1'b1) $display("FAIL poweroff_sticky: got %b want 1", o_poweroff); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0]  exp_q[$];
        logic [31:0] a, d;
        logic [3:0]  we;
        logic        hit;
        logic [15:0] m_code;
        bit          ok;
        int          m;
        m_code = 16'h0007;
        rx_q.delete();
        rx_err = 0;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin a[30] = 1'b1; a[15] = 1'b1; end
            we = 4'($urandom);
            if ($urandom_range(0, 3) != 0) we[0] = 1'b1;
            d = $urandom;
            if ($urandom_range(0, 4) < 3) d[17:16] = 2'b01;
            hit = a[30] & a[15] & we[0];
            if (hit && d[17:16] == 2'd1) exp_q.push_back(d[7:0]);
            cyc(a, we, d);
            idle($urandom_range(0, 2));
        end
        wait_drain(45 * FRAME, ok);
        chk_cnt++; if (!ok) $display("FAIL random_drain: busy still %b want 0", o_busy); else pass_cnt++;
        chk_cnt++; if (rx_q.size() != exp_q.size()) $display("FAIL random_count: got %0d want %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
        m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk_cnt++; if (rx_q[i] !== exp_q[i]) $display("FAIL random_char[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); else pass_cnt++;
        end
        chk_cnt++; if (rx_err != 0) $display("FAIL random_timing: got %0d errors want 0", rx_err); else pass_cnt++;
        chk_cnt++; if (o_exit_code !== m_code) $display("FAIL random_exit: got %h want %h", o_exit_code, m_code); else pass_cnt++;
        chk_cnt++; if (o_drop_cnt !== 8'd0) $display("FAIL random_drop: got %0d want 0", o_drop_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int sent, n, acc, m;
        bit ok;
        do_reset();
        chk_cnt++; if (o_poweroff !== 1'b0) $display("FAIL burst_reset_poweroff: got %b want 0", o_poweroff); else pass_cnt++;
        sent = 0;
        n = 0;
        while (sent < 70 && n < 2000) begin
`ifdef TOHOST_STALL_EN
            if (o_stall) begin
                idle(1);
            end else begin
                cyc(TOHOST, 4'b0001, {14'd0, 2'b01, 8'd0, burst_ch(sent)});
                sent++;
            end
`else
            cyc(TOHOST, 4'b0001, {14'd0, 2'b01, 8'd0, burst_ch(sent)});
            sent++;
`endif
            n++;
        end
        chk_cnt++; if (sent != 70) $display("FAIL burst_sent: got %0d want 70", sent); else pass_cnt++;
        wait_drain(80 * FRAME, ok);
        chk_cnt++; if (!ok) $display("FAIL burst_drain: busy still %b want 0", o_busy); else pass_cnt++;
`ifdef TOHOST_STALL_EN
        chk_cnt++; if (o_drop_cnt !== 8'd0) $display("FAIL burst_drop: got %0d want 0", o_drop_cnt); else pass_cnt++;
        acc = 70;
`else
        chk_cnt++; if (o_drop_cnt !== 8'd5 && o_drop_cnt !== 8'd6) $display("FAIL burst_drop: got %0d want 5 or 6", o_drop_cnt); else pass_cnt++;
        acc = 70 - int'(o_drop_cnt);
`endif
        chk_cnt++; if (rx_q.size() != acc) $display("FAIL burst_count: got %0d want %0d", rx_q.size(), acc); else pass_cnt++;
        m = (rx_q.size() < acc) ? rx_q.size() : acc;
        for (int i = 0; i < m; i++) begin
            chk_cnt++; if (rx_q[i] !== burst_ch(i)) $display("FAIL burst_char[%0d]: got %h want %h", i, rx_q[i], burst_ch(i)); else pass_cnt++;
        end
        chk_cnt++; if (rx_err != 0) $display("FAIL burst_timing: got %0d errors want 0", rx_err); else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        for (int i = 0; i < QS - 1; i++) cyc(TOHOST, 4'b0001, {14'd0, 2'b01, 8'd0, burst_ch(i)});
        wait_drain(QS * FRAME, ok);
        chk_cnt++; if (!ok || rx_q.size() != QS - 1) $display("FAIL wrap_fill: got %0d chars want %0d", rx_q.size(), QS - 1); else pass_cnt++;
        cyc(TOHOST, 4'b0001, 32'h0001_00A5);
        cyc(TOHOST, 4'b0001, 32'h0001_005A);
        wait_drain(4 * FRAME, ok);
        chk_cnt++; if (!ok || rx_q.size() != QS + 1) $display("FAIL wrap_count: got %0d want %0d", rx_q.size(), QS + 1); else pass_cnt++;
        if (rx_q.size() == QS + 1) begin
            chk_cnt++; if (rx_q[QS-1] !== 8'hA5) $display("FAIL wrap_char_a: got %h want a5", rx_q[QS-1]); else pass_cnt++;
            chk_cnt++; if (rx_q[QS] !== 8'h5A) $display("FAIL wrap_char_b: got %h want 5a", rx_q[QS]); else pass_cnt++;
        end
        chk_cnt++; if (o_drop_cnt !== 8'd0) $display("FAIL wrap_drop: got %0d want 0", o_drop_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int n, glitches, rx_before;
        do_reset();
        cyc(TOHOST, 4'b0001, 32'h0001_0031);
        cyc(TOHOST, 4'b0001, 32'h0001_0032);
        cyc(TOHOST, 4'b0001, 32'h0001_0033);
        n = 0;
        while (rx_q.size() < 1 && n < 3 * FRAME) begin idle(1); n++; end
        chk_cnt++; if (rx_q.size() != 1 || rx_q[0] !== 8'h31) $display("FAIL abort_first: got %0d chars want 1 (31)", rx_q.size()); else pass_cnt++;
        idle(2 * WC + WC / 2 + 2);
        RST_X = 1'b0;
        idle(1);
        chk_cnt++; if (o_txd !== 1'b1) $display("FAIL abort_txd: got %b want 1", o_txd); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", o_busy); else pass_cnt++;
        idle(2);
        RST_X = 1'b1;
        rx_before = rx_q.size();
        glitches = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            idle(1);
            if (o_txd !== 1'b1 || o_busy !== 1'b0) glitches++;
        end
        chk_cnt++; if (glitches != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", glitches); else pass_cnt++;
        chk_cnt++; if (rx_q.size() != rx_before) $display("FAIL abort_rx: got %0d chars want %0d", rx_q.size(), rx_before); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_poweroff();
        test_random();
        test_back_to_back();
        test_wrap();
        test_reset_abort();
        test_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
